pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_slot.sv | 60 ++++++
 rtl/pipe_stage_reg.sv | 172 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register.
// State encoding doubles as the occupancy count.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: load-enabled data/ctrl/tag plus valid bit.
// Clearing drops only the valid bit so the payload keeps its last value.
module pipe_slot #(
  parameter int PW     = 96,
  parameter int CTRL_W = 5,
  parameter int TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic [PW-1:0]     data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  output logic [PW-1:0]     data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic              valid_q, valid_d;
  logic [PW-1:0]     data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    tag_d   = tag_q;
    if (ld_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
      tag_d   = tag_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and flush.
// PIPE_STAGE_REG_SKID_EN selects a two-slot skid buffer with registered ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NDATA  = 3,
  parameter int CTRL_W = 5,
  parameter int TAG_W  = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NDATA*DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0]       in_ctrl_i,
  input  logic [TAG_W-1:0]        in_tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [NDATA*DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0]       out_ctrl_o,
  output logic [TAG_W-1:0]        out_tag_o,
  output logic [1:0]              occupancy_o
);

  localparam int PW = NDATA * DATA_W;

  state_e state_q, state_d;
  logic   rdy_q, rdy_d;
  logic   acc, ret;
  logic   ld0, clr0;
  logic   v0;
  logic [PW-1:0]     s0_data, d0_data;
  logic [CTRL_W-1:0] s0_ctrl, d0_ctrl;
  logic [TAG_W-1:0]  s0_tag, d0_tag;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic ld1, clr1, sel1, v1;
  logic [PW-1:0]     s1_data;
  logic [CTRL_W-1:0] s1_ctrl;
  logic [TAG_W-1:0]  s1_tag;

  assign in_ready_o = rdy_q;
`else
  assign in_ready_o = rdy_q & (~v0 | out_ready_i);
`endif

  assign acc = in_valid_i & in_ready_o;
  assign ret = v0 & out_ready_i;

  always_comb begin
    state_d = state_q;
    ld0     = 1'b0;
    clr0    = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
    ld1     = 1'b0;
    clr1    = 1'b0;
    sel1    = 1'b0;
    unique case (state_q)
      EMPTY: if (acc) begin
        ld0     = 1'b1;
        state_d = ONE;
      end
      ONE: begin
        if (acc && ret) begin
          ld0 = 1'b1;
        end else if (acc) begin
          ld1     = 1'b1;
          state_d = TWO;
        end else if (ret) begin
          clr0    = 1'b1;
          state_d = EMPTY;
        end
      end
      TWO: if (ret) begin
        ld0     = 1'b1;
        sel1    = 1'b1;
        clr1    = 1'b1;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      ld0     = 1'b0;
      ld1     = 1'b0;
      clr0    = 1'b1;
      clr1    = 1'b1;
      state_d = EMPTY;
    end
    rdy_d = (state_d != TWO);
`else
    unique case (state_q)
      EMPTY: if (acc) begin
        ld0     = 1'b1;
        state_d = ONE;
      end
      ONE: begin
        if (acc) begin
          ld0 = 1'b1;
        end else if (ret) begin
          clr0    = 1'b1;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      ld0     = 1'b0;
      clr0    = 1'b1;
      state_d = EMPTY;
    end
    rdy_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  assign d0_data = sel1 ? s1_data : in_data_i;
  assign d0_ctrl = sel1 ? s1_ctrl : in_ctrl_i;
  assign d0_tag  = sel1 ? s1_tag  : in_tag_i;

  pipe_slot #(.PW(PW), .CTRL_W(CTRL_W), .TAG_W(TAG_W)) u_slot1 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ld_i   (ld1),
    .clr_i  (clr1),
    .data_i (in_data_i),
    .ctrl_i (in_ctrl_i),
    .tag_i  (in_tag_i),
    .valid_o(v1),
    .data_o (s1_data),
    .ctrl_o (s1_ctrl),
    .tag_o  (s1_tag)
  );
`else
  assign d0_data = in_data_i;
  assign d0_ctrl = in_ctrl_i;
  assign d0_tag  = in_tag_i;
`endif

  pipe_slot #(.PW(PW), .CTRL_W(CTRL_W), .TAG_W(TAG_W)) u_slot0 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ld_i   (ld0),
    .clr_i  (clr0),
    .data_i (d0_data),
    .ctrl_i (d0_ctrl),
    .tag_i  (d0_tag),
    .valid_o(v0),
    .data_o (s0_data),
    .ctrl_o (s0_ctrl),
    .tag_o  (s0_tag)
  );

  // Bubbles must not carry side effects downstream.
  assign out_valid_o = v0;
  assign out_data_o  = s0_data;
  assign out_ctrl_o  = v0 ? s0_ctrl : '0;
  assign out_tag_o   = v0 ? s0_tag  : '0;
  assign occupancy_o = occ_t'(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (either build of
// PIPE_STAGE_REG_SKID_EN).
module tb_pipe_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [95:0] in_data_i;
  logic [4:0]  in_ctrl_i;
  logic [4:0]  in_tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [95:0] out_data_o;
  logic [4:0]  out_ctrl_o;
  logic [4:0]  out_tag_o;
  logic [1:0]  occupancy_o;

  pipe_stage_reg dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_ctrl_i  (in_ctrl_i),
    .in_tag_i   (in_tag_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_ctrl_o (out_ctrl_o),
    .out_tag_o  (out_tag_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int retired = 0;
  int seen9 = 0;
  logic [4:0] sb[$];

  function automatic logic [95:0] exp_data(input logic [4:0] t);
    return {32'(t) * 32'd3, 32'hA000_0000 | 32'(t), 32'(t) + 32'd4};
  endfunction

  function automatic logic [4:0] exp_ctrl(input logic [4:0] t);
    return t ^ 5'h15;
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic drive(input logic iv, input logic [4:0] t);
    in_valid_i = iv;
    in_tag_i   = t;
    in_data_i  = exp_data(t);
    in_ctrl_i  = exp_ctrl(t);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: pop on retire, push on accept, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (flush_i) begin
        sb.delete();
      end else begin
        if (out_valid_o && out_ready_i) begin
          if (out_tag_o == 5'd9) seen9++;
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out actual=%0d required=none",
                     out_tag_o);
          end else begin
            logic [4:0] e;
            e = sb.pop_front();
            check("sb_tag", 128'(out_tag_o), 128'(e));
            check("sb_data", 128'(out_data_o), 128'(exp_data(e)));
            check("sb_ctrl", 128'(out_ctrl_o), 128'(exp_ctrl(e)));
            retired++;
          end
        end
        if (in_valid_i && in_ready_o) sb.push_back(in_tag_i);
      end
    end
  end

  typedef struct {
    logic       iv;
    logic       ordy;
    logic [4:0] tag;
    logic       e_ov;
    logic [4:0] e_tag;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vt[9];

  initial begin
    int r0;
    vt[0] = '{1'b1, 1'b1, 5'd1, 1'b1, 5'd1, 2'd1};
    vt[1] = '{1'b1, 1'b1, 5'd2, 1'b1, 5'd2, 2'd1};
    vt[2] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0};
    vt[3] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0};
    vt[4] = '{1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 2'd1};
    vt[5] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 2'd1};
    vt[6] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0};
    vt[7] = '{1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 2'd1};
    vt[8] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0};

    rst_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, 5'd0);
    #2;
    check("rst_valid", 128'(out_valid_o), 128'd0);
    check("rst_ready", 128'(in_ready_o), 128'd0);
    check("rst_occ", 128'(occupancy_o), 128'd0);
    check("rst_data", 128'(out_data_o), 128'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    check("rel_ready", 128'(in_ready_o), 128'd1);

    // Table-driven single-entry traffic, same in both builds.
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].iv, vt[i].tag);
      out_ready_i = vt[i].ordy;
      step();
      check($sformatf("tbl%0d_valid", i), 128'(out_valid_o),
            128'(vt[i].e_ov));
      check($sformatf("tbl%0d_tag", i), 128'(out_tag_o),
            128'(vt[i].e_tag));
      check($sformatf("tbl%0d_ctrl", i), 128'(out_ctrl_o),
            128'(vt[i].e_ov ? exp_ctrl(vt[i].e_tag) : 5'd0));
      check($sformatf("tbl%0d_occ", i), 128'(occupancy_o),
            128'(vt[i].e_occ));
    end

    // Streaming: tags 1..8 back to back.
    r0 = retired;
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i));
      step();
      if (i == 1) begin
        check("strm_first_valid", 128'(out_valid_o), 128'd1);
        check("strm_first_tag", 128'(out_tag_o), 128'd1);
      end
    end
    drive(1'b0, 5'd0);
    step();
    step();
    check("strm_count", 128'(retired - r0), 128'd8);

`ifdef PIPE_STAGE_REG_SKID_EN
    // Backpressure: three offers, two fit.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd10);
    step();
    drive(1'b1, 5'd11);
    step();
    drive(1'b1, 5'd12);
    step();
    check("bp_occ", 128'(occupancy_o), 128'd2);
    check("bp_ready", 128'(in_ready_o), 128'd0);
    check("bp_head", 128'(out_tag_o), 128'd10);
    r0 = retired;
    drive(1'b0, 5'd0);
    out_ready_i = 1'b1;
    step();
    check("bp_next", 128'(out_tag_o), 128'd11);
    step();
    check("bp_drain", 128'(retired - r0), 128'd2);
    check("bp_empty", 128'(occupancy_o), 128'd0);
    // Fill to two for the flush case.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd20);
    step();
    drive(1'b1, 5'd21);
    step();
    check("fl_pre_occ", 128'(occupancy_o), 128'd2);
`else
    // Combinational ready in the single-slot build.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd10);
    step();
    drive(1'b0, 5'd0);
    #1;
    check("ns_valid", 128'(out_valid_o), 128'd1);
    check("ns_ready_lo", 128'(in_ready_o), 128'd0);
    out_ready_i = 1'b1;
    #1;
    check("ns_ready_hi", 128'(in_ready_o), 128'd1);
    step();
    check("ns_drain", 128'(occupancy_o), 128'd0);
    out_ready_i = 1'b0;
    drive(1'b1, 5'd20);
    step();
    check("fl_pre_occ", 128'(occupancy_o), 128'd1);
`endif

    // Flush with a same-edge offer of tag 9.
    flush_i = 1'b1;
    drive(1'b1, 5'd9);
    step();
    flush_i = 1'b0;
    drive(1'b0, 5'd0);
    check("fl_valid", 128'(out_valid_o), 128'd0);
    check("fl_ctrl", 128'(out_ctrl_o), 128'd0);
    check("fl_occ", 128'(occupancy_o), 128'd0);
    check("fl_ready", 128'(in_ready_o), 128'd1);
    out_ready_i = 1'b1;
    step();
    step();
    check("fl_no9", 128'(seen9), 128'd0);

    // Accept and retire on the same edge.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd30);
    step();
    drive(1'b1, 5'd31);
    out_ready_i = 1'b1;
    step();
    check("sim_occ", 128'(occupancy_o), 128'd1);
    check("sim_tag", 128'(out_tag_o), 128'd31);
    drive(1'b0, 5'd0);
    step();

    // Reset mid-transfer with one entry held.
    out_ready_i = 1'b0;
    drive(1'b1, 5'd15);
    step();
    drive(1'b0, 5'd0);
    check("mr_pre_valid", 128'(out_valid_o), 128'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    sb.delete();
    check("mr_valid", 128'(out_valid_o), 128'd0);
    check("mr_tag", 128'(out_tag_o), 128'd0);
    check("mr_data", 128'(out_data_o), 128'd0);
    check("mr_occ", 128'(occupancy_o), 128'd0);
    check("mr_ready", 128'(in_ready_o), 128'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    check("mr_rel_ready", 128'(in_ready_o), 128'd1);
    check("mr_rel_valid", 128'(out_valid_o), 128'd0);

    step();
    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
